// File: rtl/timer_pkg.sv
// Shared types and segment constants for the countdown-timer display path.
package timer_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Active-low segments, bit6..0 = g..a; all ones turns the digit off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment patterns for decimal digits 0..9 (index = digit)
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Map one BCD nibble to its segment pattern; codes 10..15 show nothing
    function automatic logic [6:0] seg_lookup(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = SEG_TABLE[0];
            4'd1:    seg = SEG_TABLE[1];
            4'd2:    seg = SEG_TABLE[2];
            4'd3:    seg = SEG_TABLE[3];
            4'd4:    seg = SEG_TABLE[4];
            4'd5:    seg = SEG_TABLE[5];
            4'd6:    seg = SEG_TABLE[6];
            4'd7:    seg = SEG_TABLE[7];
            4'd8:    seg = SEG_TABLE[8];
            4'd9:    seg = SEG_TABLE[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-nibble to active-low 7-segment decoder.
module seg7_decoder
    import timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_lookup(bcd);

endmodule

// File: rtl/timer_display_driver.sv
// Six-digit 7-segment driver for the countdown timer: serial double-dabble
// binary-to-BCD conversion, leading-zero suppression and display blanking.
module timer_display_driver
    import timer_pkg::*;
#(
    parameter int WIDTH   = 19,
    parameter int DIGITS  = 6,
    parameter int LZ_SUPP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             display_on,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5,
    output logic             busy,
    output logic             valid
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = $clog2(WIDTH + 1);

    state_t            state;
    logic [WIDTH-1:0]  sreg;
    logic [WIDTH-1:0]  last_value;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  digit_reg;
    logic [ITER_W-1:0] iter;
    logic              pending;

    logic [BCD_W-1:0]  bcd_adj;
    logic [DIGITS-1:0] lead_zero;
    logic [6:0]        dec_seg  [DIGITS];
    logic [6:0]        seg_next [DIGITS];
    logic [6:0]        hex_q    [DIGITS];

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            nib = b[4*k +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*k +: 4] = nib;
        end
        return r;
    endfunction

    assign bcd_adj = dabble_adjust(bcd);

    // Conversion sequencer: capture on change, shift WIDTH times, latch digits
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            valid      <= 1'b0;
            digit_reg  <= '0;
            last_value <= '0;
            pending    <= 1'b1;
            sreg       <= '0;
            bcd        <= '0;
            iter       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending || (value != last_value)) begin
                        sreg       <= value;
                        last_value <= value;
                        bcd        <= '0;
                        iter       <= '0;
                        pending    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[BCD_W-2:0], sreg[WIDTH-1]};
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    iter <= iter + 1'b1;
                    if (iter == ITER_W'(WIDTH - 1)) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    digit_reg <= bcd;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // One decoder per displayed digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .bcd (digit_reg[4*g +: 4]),
            .seg (dec_seg[g])
        );
    end

    // lead_zero[k] is set when digit k and every digit above it are zero
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (digit_reg[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (digit_reg[4*k +: 4] == 4'd0);
        end
    end

    // Blanking: display off / no result yet blanks all; leading zeros optionally blank
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            seg_next[k] = dec_seg[k];
            if (!display_on || !valid) begin
                seg_next[k] = SEG_BLANK;
            end else if ((LZ_SUPP != 0) && (k != 0) && lead_zero[k]) begin
                seg_next[k] = SEG_BLANK;
            end
        end
    end

    // Registered segment outputs, refreshed every clock
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DIGITS; k++) begin
                hex_q[k] <= SEG_BLANK;
            end
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                hex_q[k] <= seg_next[k];
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule
